cdf_sequencer: RTL and testbench

- Frame-level controller for the CDF pipeline.
- Waits for the histogram stage to finish a frame, then drives the fetch stage's start and bank-select inputs for exactly one 256-bin pass. It then drains the downstream pipeline and ping-pongs the histogram/CDF memory banks.
- Arbitrates the shared memory read-address port between the fetch stage and a host/debug reader.

---
 rtl/cdf_sequencer.sv | 163 ++++++++++++++++
 tb/tb_cdf_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdf_sequencer.sv
// cdf_sequencer: frame controller for the CDF pipeline. It runs one BINS-long fetch pass per histogram
// frame, drains the pipeline, ping-pongs the banks and arbitrates the read port. Watchdog: CDF_SEQ_TIMEOUT_EN.
module cdf_sequencer #(
  parameter int BINS           = 256,
  parameter int DRAIN_CYCLES   = 4,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              hist_done,
  input  logic              abort,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              cdf_start,
  output logic              cdf_bank,
  output logic              hist_bank,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              host_gnt,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              error
);

  // state     | meaning
  // IDLE      | waiting for frame_start
  // WAIT_HIST | histogram stage filling its bank
  // ARM       | one quiet cycle so fetch loads its base from a stable cdf_bank
  // RUN       | cdf_start high, one cycle per bin
  // DRAIN     | flushing the downstream pipeline
  // DONE      | frame_done pulse, banks swapped
  typedef enum logic [2:0] {S_IDLE, S_WAIT_HIST, S_ARM, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int RUN_W = (BINS > 1) ? $clog2(BINS) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(BINS - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  state_t             state_q, state_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               cdf_start_q, cdf_start_d;
  logic               cdf_bank_q, cdf_bank_d;
  logic               frame_done_q, frame_done_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               wd_expired;

`ifdef CDF_SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        error_q, error_d;

  // A hist_done in the expiring cycle still wins; abort overrides both.
  assign wd_expired = (state_q == S_WAIT_HIST) && (wd_cnt_q == WD_LAST) && !hist_done && !abort;

  always_comb begin
    wd_cnt_d = 16'd0;
    if (state_q == S_WAIT_HIST && !hist_done && !abort && !wd_expired)
      wd_cnt_d = wd_cnt_q + 16'd1;
    error_d = error_q | wd_expired;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q <= 16'd0;
      error_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      error_q  <= error_d;
    end
  end

  assign error = error_q;
`else
  assign wd_expired = 1'b0;
  assign error      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      run_cnt_q     <= '0;
      drain_cnt_q   <= '0;
      cdf_start_q   <= 1'b0;
      cdf_bank_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      cdf_start_q   <= cdf_start_d;
      cdf_bank_q    <= cdf_bank_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE:      if (frame_start) state_d = S_WAIT_HIST;
      S_WAIT_HIST: begin
        if (hist_done)       state_d = S_ARM;
        else if (wd_expired) state_d = S_IDLE;
      end
      S_ARM: begin
        state_d   = S_RUN;
        run_cnt_d = '0;
      end
      S_RUN: begin
        if (run_cnt_q == RUN_LAST) begin
          state_d     = S_DRAIN;
          run_cnt_d   = '0;
          drain_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRN_LAST) begin
          state_d     = S_DONE;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DRN_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d     = S_IDLE;
      run_cnt_d   = '0;
      drain_cnt_d = '0;
    end
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    cdf_start_d   = (state_d == S_RUN);
    frame_done_d  = (state_d == S_DONE);
    cdf_bank_d    = cdf_bank_q ^ (state_d == S_DONE);
    frame_count_d = (state_d == S_DONE) ? frame_count_q + 16'd1 : frame_count_q;
    busy          = (state_q != S_IDLE);
    host_gnt      = host_req && (state_q == S_IDLE || state_q == S_WAIT_HIST);
    if (state_q == S_ARM || state_q == S_RUN || state_q == S_DRAIN)
      mem_rd_addr = fetch_addr;
    else
      mem_rd_addr = host_addr;
  end

  assign cdf_start   = cdf_start_q;
  assign cdf_bank    = cdf_bank_q;
  assign hist_bank   = ~cdf_bank_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_cdf_sequencer.sv
// tb_cdf_sequencer: directed bench for cdf_sequencer; expected frame timing is derived from
// BINS=256, DRAIN_CYCLES=4 (ARM at sample 0, RUN 1..256, DRAIN 257..260, DONE 261 after hist_done).
module tb_cdf_sequencer;
  logic        clock = 1'b0;
  logic        reset, frame_start, hist_done, abort, host_req;
  logic [15:0] fetch_addr, host_addr;
  logic        cdf_start, cdf_bank, hist_bank, host_gnt, busy, frame_done, error;
  logic [15:0] mem_rd_addr, frame_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic exp_bank = 1'b0;

  cdf_sequencer #(.BINS(256), .DRAIN_CYCLES(4), .ADDR_W(16), .TIMEOUT_CYCLES(20)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .hist_done(hist_done),
    .abort(abort), .fetch_addr(fetch_addr), .host_req(host_req), .host_addr(host_addr),
    .cdf_start(cdf_start), .cdf_bank(cdf_bank), .hist_bank(hist_bank),
    .mem_rd_addr(mem_rd_addr), .host_gnt(host_gnt), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .error(error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic pulse_hd();
    hist_done = 1'b1; tick(); hist_done = 1'b0;
  endtask

  // Called right after the edge that sampled hist_done; injects optional events at given sample indices.
  task automatic run_after_hist(input int fs_at, input int hd_at, input int ab_at,
                                output int n_high, output int first_high, output int done_idx,
                                output int n_done, output int bank_chg, output int arb_bad,
                                output int busy_bad);
    logic b0;
    int end_idx;
    logic exp_busy, exp_fetch, exp_gnt;
    logic [15:0] exp_addr;
    b0 = cdf_bank;
    n_high = 0; first_high = -1; done_idx = -1; n_done = 0;
    bank_chg = 0; arb_bad = 0; busy_bad = 0;
    end_idx = (ab_at >= 0) ? ab_at : 261;
    for (int i = 0; i < 280; i++) begin
      if (cdf_start === 1'b1) begin n_high++; if (first_high < 0) first_high = i; end
      if (frame_done === 1'b1) begin n_done++; if (done_idx < 0) done_idx = i; end
      if (i < 261 && cdf_bank !== b0) bank_chg++;
      if (hist_bank !== ~cdf_bank) bank_chg++;
      exp_busy  = (i <= end_idx);
      exp_fetch = (i <= end_idx) && (i <= 260);
      exp_gnt   = host_req && !exp_busy;
      exp_addr  = exp_fetch ? fetch_addr : host_addr;
      if (busy !== exp_busy) busy_bad++;
      if (host_gnt !== exp_gnt || mem_rd_addr !== exp_addr) arb_bad++;
      frame_start = (i == fs_at);
      hist_done   = (i == hd_at);
      abort       = (i == ab_at);
      tick();
    end
    frame_start = 1'b0; hist_done = 1'b0; abort = 1'b0;
  endtask

  task automatic check_full_frame(input string tag, input int n_high, input int first_high,
                                  input int done_idx, input int n_done, input int bank_chg,
                                  input int arb_bad, input int busy_bad);
    checks++; if (n_high !== 256) begin errors++; $display("FAIL %s cdf_start_len: got %0d expected 256", tag, n_high); end
    checks++; if (first_high !== 1) begin errors++; $display("FAIL %s cdf_start_rise: got %0d expected 1", tag, first_high); end
    checks++; if (done_idx !== 261 || n_done !== 1) begin errors++; $display("FAIL %s frame_done: got idx %0d count %0d expected idx 261 count 1", tag, done_idx, n_done); end
    checks++; if (bank_chg !== 0) begin errors++; $display("FAIL %s bank_stable: got %0d changes expected 0", tag, bank_chg); end
    checks++; if (arb_bad !== 0 || busy_bad !== 0) begin errors++; $display("FAIL %s arb_busy: got %0d/%0d bad samples expected 0/0", tag, arb_bad, busy_bad); end
    checks++; if (cdf_bank !== exp_bank || hist_bank !== ~exp_bank) begin errors++; $display("FAIL %s banks: got %0b/%0b expected %0b/%0b", tag, cdf_bank, hist_bank, exp_bank, ~exp_bank); end
    checks++; if (frame_count !== 16'(exp_count)) begin errors++; $display("FAIL %s frame_count: got %0d expected %0d", tag, frame_count, exp_count); end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_start = 1'b1; hist_done = 1'b1; abort = 1'b0;
    host_req = 1'b0; host_addr = 16'h0; fetch_addr = 16'h0;
    repeat (3) tick();
    frame_start = 1'b0; hist_done = 1'b0; reset = 1'b0;
    tick();
    checks++; if (cdf_start !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_start_done: got %0b/%0b expected 0/0", cdf_start, frame_done); end
    checks++; if (cdf_bank !== 1'b0 || hist_bank !== 1'b1) begin errors++; $display("FAIL reset_banks: got %0b/%0b expected 0/1", cdf_bank, hist_bank); end
    checks++; if (frame_count !== 16'd0 || error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_count_err_busy: got %0d/%0b/%0b expected 0/0/0", frame_count, error, busy); end
  endtask

  task automatic test_nominal();
    int nh, fh, di, nd, bc, ab, bb;
    tick(); tick();
    pulse_fs();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nominal_wait_busy: got %0b expected 1", busy); end
    repeat (7) tick();
    pulse_hd();
    checks++; if (cdf_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL nominal_arm: got start %0b busy %0b expected 0 1", cdf_start, busy); end
    run_after_hist(-1, -1, -1, nh, fh, di, nd, bc, ab, bb);
    exp_count++; exp_bank = ~exp_bank;
    check_full_frame("nominal", nh, fh, di, nd, bc, ab, bb);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL nominal_error: got %0b expected 0", error); end
  endtask

  task automatic test_back_to_back();
    int nh, fh, di, nd, bc, ab, bb;
    for (int f = 0; f < 2; f++) begin
      checks++; if (cdf_bank !== exp_bank) begin errors++; $display("FAIL b2b_start_bank%0d: got %0b expected %0b", f, cdf_bank, exp_bank); end
      pulse_fs(); tick(); tick();
      pulse_hd();
      run_after_hist(-1, -1, -1, nh, fh, di, nd, bc, ab, bb);
      exp_count++; exp_bank = ~exp_bank;
      check_full_frame("b2b", nh, fh, di, nd, bc, ab, bb);
    end
  endtask

  task automatic test_arbitration();
    int nh, fh, di, nd, bc, ab, bb;
    host_req = 1'b1; host_addr = 16'h1234; fetch_addr = 16'h8005;
    #1;
    checks++; if (host_gnt !== 1'b1 || mem_rd_addr !== 16'h1234) begin errors++; $display("FAIL arb_idle: got gnt %0b addr %h expected 1 1234", host_gnt, mem_rd_addr); end
    pulse_fs();
    checks++; if (host_gnt !== 1'b1 || mem_rd_addr !== 16'h1234) begin errors++; $display("FAIL arb_wait: got gnt %0b addr %h expected 1 1234", host_gnt, mem_rd_addr); end
    pulse_hd();
    checks++; if (host_gnt !== 1'b0 || mem_rd_addr !== 16'h8005) begin errors++; $display("FAIL arb_arm: got gnt %0b addr %h expected 0 8005", host_gnt, mem_rd_addr); end
    run_after_hist(-1, -1, -1, nh, fh, di, nd, bc, ab, bb);
    exp_count++; exp_bank = ~exp_bank;
    check_full_frame("arb", nh, fh, di, nd, bc, ab, bb);
    host_req = 1'b0;
    #1;
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL arb_noreq: got %0b expected 0", host_gnt); end
  endtask

  task automatic test_abort();
    int nh, fh, di, nd, bc, ab, bb;
    pulse_fs(); pulse_hd();
    run_after_hist(-1, -1, 101, nh, fh, di, nd, bc, ab, bb);
    checks++; if (nh !== 101) begin errors++; $display("FAIL abort_run_len: got %0d expected 101", nh); end
    checks++; if (nd !== 0 || bb !== 0 || ab !== 0) begin errors++; $display("FAIL abort_run_done_busy: got done %0d busybad %0d arbbad %0d expected 0 0 0", nd, bb, ab); end
    checks++; if (cdf_bank !== exp_bank || frame_count !== 16'(exp_count)) begin errors++; $display("FAIL abort_run_state: got bank %0b count %0d expected %0b %0d", cdf_bank, frame_count, exp_bank, exp_count); end
    pulse_fs();
    hist_done = 1'b1; abort = 1'b1; tick(); hist_done = 1'b0; abort = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0 || cdf_start !== 1'b0) begin errors++; $display("FAIL abort_vs_hist: got busy %0b start %0b expected 0 0", busy, cdf_start); end
    pulse_fs(); pulse_hd();
    run_after_hist(-1, -1, 260, nh, fh, di, nd, bc, ab, bb);
    checks++; if (nd !== 0 || nh !== 256 || bb !== 0) begin errors++; $display("FAIL abort_drain_last: got done %0d high %0d busybad %0d expected 0 256 0", nd, nh, bb); end
    checks++; if (cdf_bank !== exp_bank || frame_count !== 16'(exp_count)) begin errors++; $display("FAIL abort_drain_state: got bank %0b count %0d expected %0b %0d", cdf_bank, frame_count, exp_bank, exp_count); end
    pulse_fs(); tick(); pulse_hd();
    run_after_hist(-1, -1, -1, nh, fh, di, nd, bc, ab, bb);
    exp_count++; exp_bank = ~exp_bank;
    check_full_frame("after_abort", nh, fh, di, nd, bc, ab, bb);
  endtask

  task automatic test_spurious();
    int nh, fh, di, nd, bc, ab, bb;
    pulse_hd();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_hist_idle: got busy %0b expected 0", busy); end
    frame_start = 1'b1; hist_done = 1'b1; tick(); frame_start = 1'b0; hist_done = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b1 || cdf_start !== 1'b0) begin errors++; $display("FAIL spur_same_cycle: got busy %0b start %0b expected 1 0", busy, cdf_start); end
    pulse_hd();
    run_after_hist(50, 120, -1, nh, fh, di, nd, bc, ab, bb);
    exp_count++; exp_bank = ~exp_bank;
    check_full_frame("spurious", nh, fh, di, nd, bc, ab, bb);
  endtask

  task automatic test_watchdog();
    int nh, fh, di, nd, bc, ab, bb;
`ifdef CDF_SEQ_TIMEOUT_EN
    pulse_fs();
    repeat (19) tick();
    pulse_hd();
    run_after_hist(-1, -1, -1, nh, fh, di, nd, bc, ab, bb);
    exp_count++; exp_bank = ~exp_bank;
    check_full_frame("wd_hist_wins", nh, fh, di, nd, bc, ab, bb);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL wd_hist_wins_error: got %0b expected 0", error); end
    pulse_fs();
    repeat (19) tick();
    checks++; if (busy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL wd_before: got busy %0b error %0b expected 1 0", busy, error); end
    tick();
    checks++; if (busy !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL wd_expire: got busy %0b error %0b expected 0 1", busy, error); end
    pulse_fs(); tick(); pulse_hd();
    run_after_hist(-1, -1, -1, nh, fh, di, nd, bc, ab, bb);
    exp_count++; exp_bank = ~exp_bank;
    check_full_frame("wd_after", nh, fh, di, nd, bc, ab, bb);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %0b expected 1", error); end
`else
    pulse_fs();
    repeat (40) tick();
    checks++; if (busy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL nowd_wait: got busy %0b error %0b expected 1 0", busy, error); end
    pulse_hd();
    run_after_hist(-1, -1, -1, nh, fh, di, nd, bc, ab, bb);
    exp_count++; exp_bank = ~exp_bank;
    check_full_frame("nowd", nh, fh, di, nd, bc, ab, bb);
`endif
  endtask

  task automatic test_reset_midframe();
    pulse_fs(); pulse_hd();
    repeat (50) tick();
    checks++; if (cdf_start !== 1'b1) begin errors++; $display("FAIL rst_mid_running: got %0b expected 1", cdf_start); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (cdf_start !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got %0b/%0b/%0b expected 0/0/0", cdf_start, busy, frame_done); end
    checks++; if (cdf_bank !== 1'b0 || hist_bank !== 1'b1 || frame_count !== 16'd0 || error !== 1'b0) begin errors++; $display("FAIL rst_mid_regs: got %0b/%0b/%0d/%0b expected 0/1/0/0", cdf_bank, hist_bank, frame_count, error); end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_arbitration();
    test_abort();
    test_spurious();
    test_watchdog();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
